// File: rtl/uart_tx_fifo_if.sv
// Byte-write and serial-status bundle between a host and uart_tx_fifo.
interface uart_tx_fifo_if #(
  parameter int unsigned FifoDepth = 4
);

  logic [7:0]                 data;
  logic                       write;
  logic                       full;
  logic [$clog2(FifoDepth):0] fifo_count;
  logic                       tx;
  logic                       busy;
  logic                       tx_done;

  // Host side: pushes bytes, observes occupancy and line state.
  modport master (
    output data,
    output write,
    input  full,
    input  fifo_count,
    input  tx,
    input  busy,
    input  tx_done
  );

  // Transmitter side.
  modport slave (
    input  data,
    input  write,
    output full,
    output fifo_count,
    output tx,
    output busy,
    output tx_done
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter running on the system clock. Bytes are queued in a
// small FIFO and sent LSB-first, back-to-back while the FIFO holds data.
module uart_tx_fifo #(
  parameter int unsigned BaudRate  = 9600,
  parameter int unsigned ClockFreq = 38400000,
  parameter int unsigned FifoDepth = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  uart_tx_fifo_if.slave bus
);

  localparam int unsigned Divisor = ClockFreq / BaudRate;
  localparam int unsigned CntW    = (Divisor > 1) ? $clog2(Divisor) : 1;
  localparam int unsigned PtrW    = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CountW  = PtrW + 1;

  localparam logic [CntW-1:0]   CntLast   = CntW'(Divisor - 1);
  localparam logic [CountW-1:0] CountFull = CountW'(FifoDepth);

  // Elaboration-time guards on parameter legality.
  if (Divisor < 2) begin : gen_bad_divisor
    $error("uart_tx_fifo: ClockFreq / BaudRate must be at least 2");
  end
  if ((FifoDepth < 2) || ((FifoDepth & (FifoDepth - 1)) != 0)) begin : gen_bad_depth
    $error("uart_tx_fifo: FifoDepth must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]        mem_q [FifoDepth];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CountW-1:0] count_q;
  logic [CountW-1:0] count_d;
  logic              full_q;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [7:0]        head;

  // A write while full is dropped even if a pop frees a slot on the same edge.
  assign push       = bus.write & ~full_q;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];

  // Storage array; contents need no reset because the count gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.data;
    end
  end

  // Occupancy next-state from the push/pop pair.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally at the power-of-two depth; full is registered from the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      full_q  <= (count_d == CountFull);
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser
  // ---------------------------------------------------------------------------
  state_e          state_q;
  state_e          state_d;
  logic [CntW-1:0] baud_cnt_q;
  logic [CntW-1:0] baud_cnt_d;
  logic [2:0]      bit_idx_q;
  logic [2:0]      bit_idx_d;
  logic [7:0]      shift_q;
  logic [7:0]      shift_d;
  logic            tx_q;
  logic            tx_d;
  logic            tx_done;
  logic            baud_last;

  assign baud_last = (baud_cnt_q == CntLast);

  // Next-state, line value and pop request for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    tx_done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        baud_cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end

      StStart: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          tx_d       = shift_q[0];
          state_d    = StData;
        end
      end

      StData: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = {1'b0, shift_q[7:1]};
            // Present the bit that becomes shift[0] after this shift.
            tx_d      = shift_q[1];
          end
        end
      end

      StStop: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          tx_done    = 1'b1;
          if (!fifo_empty) begin
            // Chain straight into the next start bit with no idle gap.
            pop     = 1'b1;
            shift_d = head;
            tx_d    = 1'b0;
            state_d = StStart;
          end else begin
            tx_d    = 1'b1;
            state_d = StIdle;
          end
        end
      end

      default: begin
        baud_cnt_d = '0;
        tx_d       = 1'b1;
        state_d    = StIdle;
      end
    endcase
  end

  // Sequencer state; reset drives the line idle-high immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.tx_done    = tx_done;
  assign bus.full       = full_q;
  assign bus.fifo_count = count_q;

endmodule
